registrador_pilha: RTL
======================

# registrador_pilha

Parametrised LIFO register stack: the next generation of the single-word enable/clear register. It holds up to DEPTH words of WIDTH bits and exposes the most recent word plus occupancy flags. It sits in the chess datapath as the move-history store for undo. Moves are pushed as they are committed and popped on undo, with overflow and underflow reported instead of corrupting state.

## Interface
- WIDTH, 12: word width in bits (12 = from-square 6 b + to-square 6 b).
- DEPTH, 8: number of stored words, ≥ 2.
- CW, $clog2(DEPTH+1): width of the occupancy count (derived, not overridden).

- clock  in  1  system clock, all state changes on rising edge.
- clear_n  in  1  reset, asynchronous and active-low.
- limpa  in  1  synchronous clear, active-high.
- push  in  1  store D as new top.
- pop  in  1  discard current top.
- D  in  WIDTH  word to push.
- Q  out  WIDTH  current top word; 0 when empty.
- count  out  CW  number of valid words, 0..DEPTH.
- vazio  out  1  count == 0.
- cheio  out  1  count == DEPTH.
- erro  out  1  one-cycle pulse: the previous edge's request was refused.

## Operation
- State: DEPTH×WIDTH storage array, pointer/count register, erro register.
- Q, vazio and cheio are decoded from registered state only; there is no combinational path from push, pop or D to any output.
- Priority per rising edge, highest first:
  - limpa: count←0, erro←0; push/pop ignored; storage contents are don't-care.
  - push & pop, count>0: top word replaced by D; count unchanged; erro←0.
  - push & pop, count==0: refused; no change; erro←1.
  - push only, count<DEPTH: word DEPTH index count←D; count←count+1; erro←0.
  - push only, count==DEPTH: refused; storage and count unchanged; erro←1.
  - pop only, count>0: count←count−1; erro←0.
  - pop only, count==0: refused; erro←1.
  - neither: hold; erro←0.
- erro is not sticky. It is high for exactly the one cycle following a refused edge.
- A refused operation never alters storage or count.
- Q = storage[count−1] when count>0, else all zeros.
- Words below the top are never modified by replace or pop.
- No wrap-around. The stack saturates at both ends; the oldest entry is never overwritten.

## Timing
- clear_n low, at any time including mid-operation, immediately forces: count=0, Q=0, vazio=1, cheio=0, erro=0. This holds until clear_n is released.
- clear_n release is sampled synchronously. The first edge with clear_n high may already execute push/pop.
- Latency: a push on edge N gives Q=D, count+1 visible after edge N (one cycle).
- A pop on edge N shows the previous word on Q after edge N.
- Back-to-back push or pop on consecutive cycles runs at full rate, one operation per clock.
- erro asserts after the refused edge and deasserts after the next edge unless that edge is also refused.
- vazio and cheio change on the same edge as count.

## Test plan
- Reset: hold clear_n=0 with push=1, D=0xABC -> Q=0, count=0, vazio=1, cheio=0, erro=0. Release clear_n, push 0x123 -> Q=0x123, count=1 after one edge.
- Fill/overflow (DEPTH=8): push 0x001..0x008 -> cheio=1, Q=0x008. Push 0x0FF -> erro=1 for one cycle, Q=0x008, count=8. Next idle cycle -> erro=0.
- Drain/underflow: from full, pop 8× -> Q steps 0x007…0x001, then 0, vazio=1. A 9th pop -> erro pulse, count stays 0.
- Simultaneous: with count=3, Q=0x030, push+pop D=0x3F0 -> Q=0x3F0, count=3. After one pop -> Q is the original second entry.
- Simultaneous when empty: push+pop D=0x555 -> erro=1, count=0, Q=0. Same request with count=8 -> top replaced, no erro.
- Sync vs async clear: limpa=1 with push=1 at count=5 -> count=0, erro=0 next cycle. Assert clear_n mid-sequence between edges -> outputs reset immediately, not at the next edge.

Source files
------------

// File: rtl/registrador_pilha.sv
// LIFO register stack of DEPTH words of WIDTH bits (move-history store for undo).
// Refused pushes and pops raise a one-cycle erro pulse and leave the stack untouched.
module registrador_pilha #(
   parameter  int WIDTH = 12,
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             limpa,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [CW-1:0]    count,
   output logic             vazio,
   output logic             cheio,
   output logic             erro
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_CLEAR,
      OP_PUSH,
      OP_POP,
      OP_REPLACE,
      OP_REFUSE
   } op_t;

   op_t              op;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count_nxt;
   logic             erro_nxt;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             empty;
   logic             full;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign top_idx = AW'(count - CW'(1));

   // limpa outranks everything; a refused request is folded into one op so it cannot touch state
   always_comb begin
      op = OP_IDLE;
      if (limpa)
         op = OP_CLEAR;
      else if (push && pop)
         op = empty ? OP_REFUSE : OP_REPLACE;
      else if (push)
         op = full ? OP_REFUSE : OP_PUSH;
      else if (pop)
         op = empty ? OP_REFUSE : OP_POP;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      count_nxt = count;
      erro_nxt  = 1'b0;
      wr_idx    = top_idx;
      unique case (op)
         OP_CLEAR:  count_nxt = '0;
         OP_PUSH: begin
            count_nxt = count + CW'(1);
            wr_idx    = AW'(count);
         end
         OP_POP:    count_nxt = count - CW'(1);
         OP_REFUSE: erro_nxt  = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
         erro  <= 1'b0;
      end else begin
         count <= count_nxt;
         erro  <= erro_nxt;
      end
   end

   // NOTE: storage has no reset; words above count are never observable on Q.
   always_ff @(posedge clock) begin
      if (op == OP_PUSH || op == OP_REPLACE)
         mem[wr_idx] <= D;
   end

   always_comb begin
      Q = '0;
      if (!empty)
         Q = mem[top_idx];
   end

   assign vazio = empty;
   assign cheio = full;

endmodule
